writing_address_verifier: RTL and testbench
===========================================

Name: writing_address_verifier

Overview:
- Sits in the Avalon-MM write path between a write master and the partitioned memory.
- Decodes each write address to one of 5 partitions. Forwards the write only if that partition's write enable is set; otherwise the write is dropped.
- Partition enables come from the Avalon debugger register block.
- Publishes a 5-bit event code on dbg_info, which the debugger logs on every change, and keeps a saturating violation count.

Parameters:
- ADDR_W, 24, slave/master address width in bits.
- DATA_W, 64, write data width in bits; byteenable width is DATA_W/8.
- PARTITION_SHIFT, 20, partition index = address >> PARTITION_SHIFT.
- NUM_PARTITIONS, 5, number of valid partitions; indices at or above this are out of range.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- s_address  in  ADDR_W  upstream write address
- s_write  in  1  upstream write request
- s_writedata  in  DATA_W  upstream write data
- s_byteenable  in  DATA_W/8  upstream byte enables
- s_waitrequest  out  1  stall to upstream
- m_address  out  ADDR_W  downstream write address
- m_write  out  1  downstream write request
- m_writedata  out  DATA_W  downstream write data
- m_byteenable  out  DATA_W/8  downstream byte enables
- m_waitrequest  in  1  stall from downstream
- partition_write_enables  in  5  per-partition write permit, bit i = partition i
- clear_err  in  1  clears err_sticky and violation_count
- dbg_info  out  5  event code, to the debugger
- err_sticky  out  1  set on any rejected write
- violation_count  out  16  saturating count of rejected writes

Behaviour:
- Reset values: all outputs 0, state IDLE, m_* registers 0. Reset is asynchronous, so m_write drops immediately and any in-flight write is discarded.
- Handshake: a slave write is accepted when s_write=1 and s_waitrequest=0. s_waitrequest=0 only in IDLE.
- FSM states: IDLE, FORWARD, DROP.
- IDLE with s_write=1, on acceptance:
  - Compute idx = s_address >> PARTITION_SHIFT.
  - Sample partition_write_enables in this same cycle.
  - If idx < NUM_PARTITIONS and enable[idx]=1: latch address, data and byteenable into the m_* registers; m_write<=1; go to FORWARD.
  - Else go to DROP.
- FORWARD:
  - m_write held at 1 and m_* stable until m_waitrequest=0.
  - On that cycle: m_write<=0, dbg event FWD, go to IDLE.
  - Enable changes during FORWARD have no effect.
- DROP:
  - Exactly 1 cycle.
  - dbg event DIS if idx was in range, OOR if out of range.
  - err_sticky<=1; violation_count increments and saturates at 0xFFFF; go to IDLE.
- Throughput: minimum 2 cycles per write (accept, then complete). Forward latency is 1 cycle from acceptance to m_write=1.
- dbg_info encoding:
  - Bits [4:3] = type: 00 idle, 01 FWD, 10 DIS, 11 OOR.
  - Bits [2:0] = idx[2:0], forced to 0 for the idle code.
- dbg_info timing:
  - Registered. Equals the event code for exactly the cycle after completion, then 00000.
  - A completion cannot occur in the cycle immediately following another completion, so dbg_info always returns to 00000 between events and consecutive identical events each produce a change.
- clear_err:
  - Synchronous. Clears err_sticky and violation_count.
  - If asserted in the same cycle as a DROP completion, the clear wins: count=0, err=0.
- idx width: full (ADDR_W-PARTITION_SHIFT) bits are compared, so addresses with any upper index bits set are OOR, never aliased.

Decomposition:
- Package wav_pkg holds:
  - state enum {IDLE, FORWARD, DROP};
  - dbg type constants DBG_IDLE=2'b00, DBG_FWD=2'b01, DBG_DIS=2'b10, DBG_OOR=2'b11;
  - NUM_PARTITIONS=5.
- One combinational sub-module, partition_decoder: address and enables in; idx, in_range and permitted out.

Test Plan:
- Enables=5'b11111; write addr 0x200010, data 0xA5 (idx 2), m_waitrequest=0 -> m_write high 1 cycle after acceptance with addr 0x200010; dbg_info=5'b01010 for 1 cycle, then 0.
- Enables=5'b11011; write addr 0x300000 (idx 3) -> no m_write; dbg_info=5'b10011; err_sticky=1; violation_count=1.
- Write addr 0x500000 (idx 5) -> dbg_info=5'b11101; violation_count increments. Write addr 0xF00000 -> OOR, dbg_info=5'b11111.
- m_waitrequest held high 4 cycles during FORWARD, with enables toggled to 0 meanwhile -> m_* stable, s_waitrequest=1 throughout, write completes as FWD.
- Two back-to-back rejected writes to idx 3 -> dbg_info sequence 10011, 00000, 10011; count=2. Then pulse clear_err -> count=0, err=0.
- Assert reset while in FORWARD -> m_write=0 immediately, state IDLE, all outputs 0; a subsequent write to an enabled partition works normally.

Source files
------------

// File: rtl/wav_pkg.sv
// wav_pkg: shared FSM states, debug event type codes and partition count for writing_address_verifier
package wav_pkg;
    typedef enum logic [1:0] {IDLE, FORWARD, DROP} state_t;
    localparam logic [1:0] DBG_IDLE = 2'b00;
    localparam logic [1:0] DBG_FWD  = 2'b01;
    localparam logic [1:0] DBG_DIS  = 2'b10;
    localparam logic [1:0] DBG_OOR  = 2'b11;
    localparam int NUM_PARTITIONS = 5;
endpackage

// File: rtl/partition_decoder.sv
// partition_decoder: maps the partition field of a write address to a partition and checks its write permit
//   address_field  in   partition field of the address (address >> PARTITION_SHIFT), full width
//   enables        in   per-partition write permits, bit i = partition i
//   idx            out  low three bits of the partition index, used in event codes
//   in_range       out  index is below NUM_PARTITIONS
//   permitted      out  index is in range and its permit bit is set
module partition_decoder #(
    parameter int IDX_W          = 4,
    parameter int NUM_PARTITIONS = wav_pkg::NUM_PARTITIONS
) (
    input  logic [IDX_W-1:0] address_field,
    input  logic [4:0]       enables,
    output logic [2:0]       idx,
    output logic             in_range,
    output logic             permitted
);
    localparam logic [IDX_W-1:0] LIMIT = IDX_W'(NUM_PARTITIONS);
    logic [4:0] shifted;
    always_comb begin
        shifted   = enables >> address_field;
        in_range  = address_field < LIMIT;
        permitted = in_range & shifted[0];
        idx       = address_field[2:0];
    end
endmodule

// File: rtl/writing_address_verifier.sv
// writing_address_verifier: forwards Avalon-MM writes only to partitions whose write permit is set
//   clock, reset                  clock; asynchronous active-high reset
//   s_address/s_write/s_writedata/s_byteenable/s_waitrequest  upstream write slave
//   m_address/m_write/m_writedata/m_byteenable/m_waitrequest  downstream write master
//   partition_write_enables       per-partition write permits
//   clear_err                     clears err_sticky and violation_count
//   dbg_info                      one-cycle event code {type, idx[2:0]} after each completion
//   err_sticky, violation_count   rejected-write flag and saturating count
module writing_address_verifier #(
    parameter int ADDR_W          = 24,
    parameter int DATA_W          = 64,
    parameter int PARTITION_SHIFT = 20,
    parameter int NUM_PARTITIONS  = wav_pkg::NUM_PARTITIONS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   s_address,
    input  logic                s_write,
    input  logic [DATA_W-1:0]   s_writedata,
    input  logic [DATA_W/8-1:0] s_byteenable,
    output logic                s_waitrequest,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [4:0]          partition_write_enables,
    input  logic                clear_err,
    output logic [4:0]          dbg_info,
    output logic                err_sticky,
    output logic [15:0]         violation_count
);
    import wav_pkg::*;
    state_t     state;
    logic [2:0] idx, idx_q;
    logic       in_range, permitted, oor_q;
    partition_decoder #(
        .IDX_W(ADDR_W - PARTITION_SHIFT),
        .NUM_PARTITIONS(NUM_PARTITIONS)
    ) u_decoder (
        .address_field(s_address[ADDR_W-1:PARTITION_SHIFT]),
        .enables(partition_write_enables),
        .idx(idx),
        .in_range(in_range),
        .permitted(permitted)
    );
    assign s_waitrequest = state != IDLE;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            m_address       <= '0;
            m_write         <= 1'b0;
            m_writedata     <= '0;
            m_byteenable    <= '0;
            idx_q           <= '0;
            oor_q           <= 1'b0;
            dbg_info        <= '0;
            err_sticky      <= 1'b0;
            violation_count <= '0;
        end else begin
            dbg_info <= {DBG_IDLE, 3'b000};
            if (state == IDLE && s_write) begin
                idx_q <= idx;
                oor_q <= !in_range;
                if (permitted) begin
                    m_address    <= s_address;
                    m_writedata  <= s_writedata;
                    m_byteenable <= s_byteenable;
                    m_write      <= 1'b1;
                    state        <= FORWARD;
                end else begin
                    state <= DROP;
                end
            end else if (state == FORWARD && !m_waitrequest) begin
                m_write  <= 1'b0;
                dbg_info <= {DBG_FWD, idx_q};
                state    <= IDLE;
            end else if (state == DROP) begin
                dbg_info        <= {oor_q ? DBG_OOR : DBG_DIS, idx_q};
                err_sticky      <= 1'b1;
                violation_count <= (&violation_count) ? violation_count : violation_count + 16'd1;
                state           <= IDLE;
            end
            // a clear in the same cycle as a drop completion takes priority
            if (clear_err) begin
                err_sticky      <= 1'b0;
                violation_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_writing_address_verifier.sv
// tb_writing_address_verifier: directed and randomized checks against a transaction-level model
module tb_writing_address_verifier;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] s_address = '0;
    logic        s_write = 1'b0;
    logic [63:0] s_writedata = '0;
    logic [7:0]  s_byteenable = '0;
    logic        s_waitrequest;
    logic [23:0] m_address;
    logic        m_write;
    logic [63:0] m_writedata;
    logic [7:0]  m_byteenable;
    logic        m_waitrequest = 1'b0;
    logic [4:0]  partition_write_enables = '0;
    logic        clear_err = 1'b0;
    logic [4:0]  dbg_info;
    logic        err_sticky;
    logic [15:0] violation_count;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_cnt = '0;
    logic        exp_err = 1'b0;

    writing_address_verifier dut (
        .clock(clock), .reset(reset),
        .s_address(s_address), .s_write(s_write), .s_writedata(s_writedata),
        .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
        .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
        .partition_write_enables(partition_write_enables), .clear_err(clear_err),
        .dbg_info(dbg_info), .err_sticky(err_sticky), .violation_count(violation_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_m_write"}, m_write, 0);
        check({tag, "_m_address"}, m_address, 0);
        check({tag, "_m_writedata"}, m_writedata, 0);
        check({tag, "_m_byteenable"}, m_byteenable, 0);
        check({tag, "_s_waitrequest"}, s_waitrequest, 0);
        check({tag, "_dbg"}, dbg_info, 0);
        check({tag, "_err"}, err_sticky, 0);
        check({tag, "_count"}, violation_count, 0);
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling edge after completion.
    task automatic do_write(input logic [23:0] addr, input logic [63:0] data, input logic [7:0] be,
                            input logic [4:0] en, input int stall, input bit clr);
        logic [3:0] idx;
        logic [4:0] code;
        bit         ok;
        idx = addr[23:20];
        ok = (idx < 4'd5) && en[idx[2:0]];
        s_address = addr;
        s_writedata = data;
        s_byteenable = be;
        partition_write_enables = en;
        s_write = 1'b1;
        m_waitrequest = 1'b1;
        check("accept_ready", s_waitrequest, 0);
        @(negedge clock);
        s_write = 1'b0;
        s_address = 24'($urandom);
        s_writedata = {$urandom, $urandom};
        s_byteenable = 8'($urandom);
        check("busy_after_accept", s_waitrequest, 1);
        check("dbg_quiet_after_accept", dbg_info, 0);
        if (ok) begin
            check("fwd_m_write", m_write, 1);
            check("fwd_addr", m_address, addr);
            check("fwd_data", m_writedata, data);
            check("fwd_be", m_byteenable, be);
            for (int k = 0; k < stall; k++) begin
                partition_write_enables = k[0] ? 5'($urandom) : 5'b00000;
                @(negedge clock);
                check("stall_m_write", m_write, 1);
                check("stall_addr", m_address, addr);
                check("stall_data", m_writedata, data);
                check("stall_busy", s_waitrequest, 1);
                check("stall_dbg", dbg_info, 0);
            end
            m_waitrequest = 1'b0;
            @(negedge clock);
            check("fwd_done_m_write", m_write, 0);
            code = {2'b01, idx[2:0]};
        end else begin
            check("drop_no_m_write", m_write, 0);
            clear_err = clr;
            @(negedge clock);
            clear_err = 1'b0;
            check("drop_no_m_write2", m_write, 0);
            exp_err = !clr;
            exp_cnt = clr ? 16'd0 : (exp_cnt == 16'hFFFF ? exp_cnt : exp_cnt + 16'd1);
            code = {(idx < 4'd5) ? 2'b10 : 2'b11, idx[2:0]};
        end
        check("dbg_event", dbg_info, code);
        check("err_sticky", err_sticky, exp_err);
        check("violation_count", violation_count, exp_cnt);
        check("ready_after_done", s_waitrequest, 0);
    endtask

    initial begin
        #2;
        check_idle_outputs("reset");
        @(negedge clock);
        reset = 1'b0;
        do_write(24'h200010, 64'hA5, 8'hFF, 5'b11111, 0, 0);
        @(negedge clock);
        check("fwd_dbg_cleared", dbg_info, 0);
        do_write(24'h300000, 64'h1, 8'h0F, 5'b11011, 0, 0);
        do_write(24'h500000, 64'h2, 8'hF0, 5'b11111, 0, 0);
        do_write(24'hF00000, 64'h3, 8'h01, 5'b11111, 0, 0);
        do_write(24'h100123, 64'hDEAD_BEEF_0123_4567, 8'h3C, 5'b00010, 4, 0);
        do_write(24'h300004, 64'h4, 8'h11, 5'b10111, 0, 0);
        do_write(24'h300008, 64'h5, 8'h22, 5'b10111, 0, 0);
        do_write(24'h300008, 64'h5, 8'h22, 5'b10111, 0, 1);
        do_write(24'h3000AA, 64'h6, 8'h33, 5'b00000, 0, 0);
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
        exp_cnt = '0;
        exp_err = 1'b0;
        check("clear_count", violation_count, 0);
        check("clear_err", err_sticky, 0);
        do_write(24'h400000, 64'h7, 8'h44, 5'b01111, 0, 0);
        // reset while a forwarded write is stalled downstream
        s_address = 24'h000040;
        s_writedata = 64'h77;
        s_byteenable = 8'hFF;
        partition_write_enables = 5'b00001;
        m_waitrequest = 1'b1;
        s_write = 1'b1;
        @(negedge clock);
        s_write = 1'b0;
        check("pre_reset_m_write", m_write, 1);
        #2 reset = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        @(negedge clock);
        reset = 1'b0;
        exp_cnt = '0;
        exp_err = 1'b0;
        do_write(24'h000040, 64'h88, 8'hAA, 5'b00001, 1, 0);
        for (int n = 0; n < 40; n++) begin
            logic [3:0] ridx;
            ridx = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
            do_write({ridx, 20'($urandom)}, {$urandom, $urandom}, 8'($urandom), 5'($urandom),
                     int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) @(negedge clock);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
